// File: rtl/button_conditioner_pkg.sv
// Shared types and constants for the four-button debounce/auto-repeat front end.
package button_conditioner_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRESS_WAIT,
    ST_HELD,
    ST_REPEAT,
    ST_RELEASE_WAIT
  } chan_state_t;

  // Bit positions inside the packed {up,down,left,right} vectors.
  localparam logic [1:0] DIR_UP    = 2'd3;
  localparam logic [1:0] DIR_DOWN  = 2'd2;
  localparam logic [1:0] DIR_LEFT  = 2'd1;
  localparam logic [1:0] DIR_RIGHT = 2'd0;

  localparam int unsigned DEF_DEBOUNCE_CYCLES = 1_000_000;
  localparam int unsigned DEF_REPEAT_DELAY    = 50_000_000;
  localparam int unsigned DEF_REPEAT_PERIOD   = 20_000_000;

  // Counter width for terminal count n-1, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// One button: 2-flop synchronizer, debounce FSM and auto-repeat timer.
module debounce_channel
  import button_conditioner_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int unsigned REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_raw_n,
  output logic o_strobe_n,
  output logic o_held
);

  localparam int unsigned CW   = cnt_width(DEBOUNCE_CYCLES);
  localparam int unsigned RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned RW   = cnt_width(RMAX);

  localparam logic [CW-1:0] CNT_LAST    = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [RW-1:0] DELAY_LAST  = RW'((REPEAT_DELAY  == 0) ? 0 : REPEAT_DELAY  - 1);
  localparam logic [RW-1:0] PERIOD_LAST = RW'((REPEAT_PERIOD == 0) ? 0 : REPEAT_PERIOD - 1);
  localparam bit            REPEAT_EN   = (REPEAT_DELAY != 0);

  logic          r_sync1;
  logic          r_sync2;
  chan_state_t   r_state;
  logic [CW-1:0] r_cnt;
  logic [RW-1:0] r_rcnt;
  logic          r_from_repeat;
  logic          r_strobe_n;
  logic          r_held;
  logic          w_pressed;

  assign w_pressed  = ~r_sync2;
  assign o_strobe_n = r_strobe_n;
  assign o_held     = r_held;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1       <= 1'b1;
      r_sync2       <= 1'b1;
      r_state       <= ST_IDLE;
      r_cnt         <= '0;
      r_rcnt        <= '0;
      r_from_repeat <= 1'b0;
      r_strobe_n    <= 1'b1;
      r_held        <= 1'b0;
    end else begin
      r_sync1    <= i_raw_n;
      r_sync2    <= r_sync1;
      r_strobe_n <= 1'b1;
      unique case (r_state)
        ST_IDLE: begin
          if (w_pressed) begin
            r_state <= ST_PRESS_WAIT;
            r_cnt   <= '0;
          end
        end
        ST_PRESS_WAIT: begin
          if (!w_pressed) begin
            r_state <= ST_IDLE;
          end else if (r_cnt == CNT_LAST) begin
            r_state    <= ST_HELD;
            r_strobe_n <= 1'b0;
            r_held     <= 1'b1;
            r_rcnt     <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_HELD: begin
          if (!w_pressed) begin
            r_state       <= ST_RELEASE_WAIT;
            r_cnt         <= '0;
            r_from_repeat <= 1'b0;
          end else if (REPEAT_EN) begin
            if (r_rcnt == DELAY_LAST) begin
              r_state    <= ST_REPEAT;
              r_strobe_n <= 1'b0;
              r_rcnt     <= '0;
            end else begin
              r_rcnt <= r_rcnt + 1'b1;
            end
          end
        end
        ST_REPEAT: begin
          if (!w_pressed) begin
            r_state       <= ST_RELEASE_WAIT;
            r_cnt         <= '0;
            r_from_repeat <= 1'b1;
          end else if (r_rcnt == PERIOD_LAST) begin
            r_strobe_n <= 1'b0;
            r_rcnt     <= '0;
          end else begin
            r_rcnt <= r_rcnt + 1'b1;
          end
        end
        ST_RELEASE_WAIT: begin
          // A release bounce resumes the hold phase with the repeat timer frozen, not restarted.
          if (w_pressed) begin
            r_state <= r_from_repeat ? ST_REPEAT : ST_HELD;
            r_cnt   <= '0;
          end else if (r_cnt == CNT_LAST) begin
            r_state <= ST_IDLE;
            r_held  <= 1'b0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/button_conditioner.sv
// Four independent debounced, auto-repeating move strobes for the frogger block.
module button_conditioner
  import button_conditioner_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int unsigned REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_up_raw,
  input  logic       btn_down_raw,
  input  logic       btn_left_raw,
  input  logic       btn_right_raw,
  output logic       up,
  output logic       down,
  output logic       left,
  output logic       right,
  output logic [3:0] held
);

  logic [3:0] w_raw_n;
  logic [3:0] w_strobe_n;
  logic [3:0] w_held;

  assign w_raw_n[DIR_UP]    = btn_up_raw;
  assign w_raw_n[DIR_DOWN]  = btn_down_raw;
  assign w_raw_n[DIR_LEFT]  = btn_left_raw;
  assign w_raw_n[DIR_RIGHT] = btn_right_raw;

  for (genvar g = 0; g < 4; g++) begin : g_chan
    debounce_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_PERIOD  (REPEAT_PERIOD)
    ) u_chan (
      .clk       (clk),
      .rst_n     (reset),
      .i_raw_n   (w_raw_n[g]),
      .o_strobe_n(w_strobe_n[g]),
      .o_held    (w_held[g])
    );
  end

  assign up    = w_strobe_n[DIR_UP];
  assign down  = w_strobe_n[DIR_DOWN];
  assign left  = w_strobe_n[DIR_LEFT];
  assign right = w_strobe_n[DIR_RIGHT];
  assign held  = w_held;

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: two instances (repeat on / repeat off) against a run-length reference model.
module tb_button_conditioner;

  localparam int D    = 4;
  localparam int RD_A = 20;
  localparam int RD_B = 0;
  localparam int RP   = 8;

  logic       clk   = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] raw   = 4'hF;   // {up,down,left,right}, low = pressed

  logic       up_a, down_a, left_a, right_a;
  logic [3:0] held_a;
  logic       up_b, down_b, left_b, right_b;
  logic [3:0] held_b;
  logic [7:0] o_a, o_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  button_conditioner #(.DEBOUNCE_CYCLES(D), .REPEAT_DELAY(RD_A), .REPEAT_PERIOD(RP)) dut_a (
    .clk(clk), .reset(reset),
    .btn_up_raw(raw[3]), .btn_down_raw(raw[2]), .btn_left_raw(raw[1]), .btn_right_raw(raw[0]),
    .up(up_a), .down(down_a), .left(left_a), .right(right_a), .held(held_a)
  );

  button_conditioner #(.DEBOUNCE_CYCLES(D), .REPEAT_DELAY(RD_B), .REPEAT_PERIOD(RP)) dut_b (
    .clk(clk), .reset(reset),
    .btn_up_raw(raw[3]), .btn_down_raw(raw[2]), .btn_left_raw(raw[1]), .btn_right_raw(raw[0]),
    .up(up_b), .down(down_b), .left(left_b), .right(right_b), .held(held_b)
  );

  assign o_a = {up_a, down_a, left_a, right_a, held_a};
  assign o_b = {up_b, down_b, left_b, right_b, held_b};

  // Reference model: pressed level flips after D+1 consecutive disagreeing synchronized
  // samples; repeat strobes fire after RD (then RP) undisturbed hold samples.
  bit         h1  [2][4];
  bit         h2  [2][4];
  bit         lvl [2][4];
  bit         rep [2][4];
  bit         sn  [2][4];
  int         run [2][4];
  int         acc [2][4];
  logic [7:0] m_exp [2];

  always @(posedge clk or negedge reset) begin
    for (int d = 0; d < 2; d++) begin
      for (int ch = 0; ch < 4; ch++) begin
        if (!reset) begin
          h1[d][ch] = 1'b1; h2[d][ch] = 1'b1; lvl[d][ch] = 1'b0; rep[d][ch] = 1'b0;
          sn[d][ch] = 1'b1; run[d][ch] = 0;   acc[d][ch] = 0;
        end else begin
          int rdv;
          bit p;
          rdv = (d == 0) ? RD_A : RD_B;
          p = !h2[d][ch];
          h2[d][ch] = h1[d][ch];
          h1[d][ch] = raw[ch];
          sn[d][ch] = 1'b1;
          if (p != lvl[d][ch]) begin
            run[d][ch]++;
            if (run[d][ch] == D + 1) begin
              lvl[d][ch] = p; run[d][ch] = 0; acc[d][ch] = 0; rep[d][ch] = 1'b0;
              if (p) sn[d][ch] = 1'b0;
            end
          end else begin
            if (lvl[d][ch] && run[d][ch] == 0 && rdv != 0) begin
              acc[d][ch]++;
              if (acc[d][ch] == (rep[d][ch] ? RP : rdv)) begin
                sn[d][ch] = 1'b0; rep[d][ch] = 1'b1; acc[d][ch] = 0;
              end
            end
            run[d][ch] = 0;
          end
        end
      end
      m_exp[d] = {sn[d][3], sn[d][2], sn[d][1], sn[d][0], lvl[d][3], lvl[d][2], lvl[d][1], lvl[d][0]};
    end
  end

  task automatic idle(input int n);
    raw = 4'hF;
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    raw   = 4'h0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checks++;
      if (o_a !== 8'hF0 || o_b !== 8'hF0)
        begin errors++; $display("FAIL reset_hold k=%0d got=%h/%h exp=f0/f0", k, o_a, o_b); end
    end
    reset = 1'b1;
    for (int k = 0; k < 10; k++) begin
      logic [7:0] e;
      @(negedge clk);
      e = {(k == 6) ? 4'h0 : 4'hF, (k >= 6) ? 4'hF : 4'h0};
      checks++;
      if (o_a !== e || o_b !== e)
        begin errors++; $display("FAIL reset_first_strobe k=%0d got=%h/%h exp=%h", k, o_a, o_b, e); end
      checks++;
      if (o_a !== m_exp[0] || o_b !== m_exp[1])
        begin errors++; $display("FAIL reset_model k=%0d got=%h/%h exp=%h/%h", k, o_a, o_b, m_exp[0], m_exp[1]); end
    end
    idle(15);
  endtask

  task automatic test_clean_press();
    raw = 4'b0111;
    for (int k = 0; k < 112; k++) begin
      logic eu, eh;
      @(negedge clk);
      eu = !(k == 6 || (k >= 26 && k <= 98 && (k - 26) % 8 == 0));
      eh = (k >= 6 && k < 106);
      checks++;
      if ({up_a, held_a[3]} !== {eu, eh})
        begin errors++; $display("FAIL clean_press k=%0d got up=%b held=%b exp up=%b held=%b", k, up_a, held_a[3], eu, eh); end
      checks++;
      if (o_a !== m_exp[0] || o_b !== m_exp[1])
        begin errors++; $display("FAIL clean_model k=%0d got=%h/%h exp=%h/%h", k, o_a, o_b, m_exp[0], m_exp[1]); end
      raw[3] = (k + 1 < 100) ? 1'b0 : 1'b1;
    end
    idle(5);
  endtask

  task automatic test_bounce();
    raw[1] = 1'b0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      checks++;
      if ({left_a, held_a[1]} !== {(k != 6 + 30), (k >= 36)})
        begin errors++; $display("FAIL bounce k=%0d got left=%b held=%b exp left=%b held=%b", k, left_a, held_a[1], (k != 36), (k >= 36)); end
      checks++;
      if (o_a !== m_exp[0] || o_b !== m_exp[1])
        begin errors++; $display("FAIL bounce_model k=%0d got=%h/%h exp=%h/%h", k, o_a, o_b, m_exp[0], m_exp[1]); end
      raw[1] = (k + 1 < 30) ? ((k + 1) % 3 == 2) : 1'b0;
    end
    idle(10);
  endtask

  task automatic test_release_bounce();
    raw[0] = 1'b0;
    for (int k = 0; k < 41; k++) begin
      @(negedge clk);
      checks++;
      if ({right_a, held_a[0]} !== {(k != 6), (k >= 6 && k < 31)})
        begin errors++; $display("FAIL release_bounce k=%0d got right=%b held=%b exp right=%b held=%b", k, right_a, held_a[0], (k != 6), (k >= 6 && k < 31)); end
      checks++;
      if (o_a !== m_exp[0] || o_b !== m_exp[1])
        begin errors++; $display("FAIL release_model k=%0d got=%h/%h exp=%h/%h", k, o_a, o_b, m_exp[0], m_exp[1]); end
      raw[0] = (k + 1 == 17 || k + 1 == 18 || k + 1 >= 25);
    end
    idle(5);
  endtask

  task automatic test_simultaneous();
    raw = 4'b0110;
    for (int k = 0; k < 10; k++) begin
      logic [3:0] e;
      @(negedge clk);
      e = (k == 6) ? 4'b0110 : 4'b1111;
      checks++;
      if ({up_a, down_a, left_a, right_a} !== e)
        begin errors++; $display("FAIL simultaneous k=%0d got=%b exp=%b", k, {up_a, down_a, left_a, right_a}, e); end
    end
    idle(10);
  endtask

  task automatic test_repeat_disabled();
    raw = 4'b1011;
    for (int k = 0; k < 210; k++) begin
      @(negedge clk);
      checks++;
      if ({down_b, held_b[2]} !== {(k != 6), (k >= 6 && k < 206)})
        begin errors++; $display("FAIL repeat_disabled k=%0d got down=%b held=%b exp down=%b held=%b", k, down_b, held_b[2], (k != 6), (k >= 6 && k < 206)); end
      checks++;
      if (o_a !== m_exp[0] || o_b !== m_exp[1])
        begin errors++; $display("FAIL norepeat_model k=%0d got=%h/%h exp=%h/%h", k, o_a, o_b, m_exp[0], m_exp[1]); end
      raw[2] = (k + 1 >= 200);
    end
    idle(5);
  endtask

  task automatic test_reset_mid_press();
    raw = 4'b0111;
    repeat (4) @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if (o_a !== 8'hF0)
        begin errors++; $display("FAIL mid_reset_hold k=%0d got=%h exp=f0", k, o_a); end
    end
    reset = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      checks++;
      if ({up_a, held_a[3]} !== {(k != 6), (k >= 6)})
        begin errors++; $display("FAIL mid_reset_restart k=%0d got up=%b held=%b exp up=%b held=%b", k, up_a, held_a[3], (k != 6), (k >= 6)); end
    end
    idle(10);
  endtask

  task automatic test_random();
    int left_cnt [4];
    for (int ch = 0; ch < 4; ch++) left_cnt[ch] = $urandom_range(1, 8);
    for (int k = 0; k < 1600; k++) begin
      @(negedge clk);
      checks++;
      if (o_a !== m_exp[0] || o_b !== m_exp[1])
        begin errors++; $display("FAIL random_model k=%0d got=%h/%h exp=%h/%h", k, o_a, o_b, m_exp[0], m_exp[1]); end
      reset = (k >= 800 && k < 803) ? 1'b0 : 1'b1;
      for (int ch = 0; ch < 4; ch++) begin
        left_cnt[ch]--;
        if (left_cnt[ch] <= 0) begin
          raw[ch] = ~raw[ch];
          left_cnt[ch] = ($urandom_range(0, 3) == 0) ? $urandom_range(20, 60) : $urandom_range(1, 7);
        end
      end
    end
    reset = 1'b1;
    idle(10);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_release_bounce();
    test_simultaneous();
    test_repeat_disabled();
    test_reset_mid_press();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/button_conditioner.md
Name: button_conditioner

Overview:
- Upstream stage for the frogger logic block.
- Takes the four raw, bouncing, asynchronous active-low push-buttons (up/down/left/right).
- Emits clean one-clock active-low move strobes, so frogger advances exactly one cell per press instead of one cell per clock.
- Optional auto-repeat while a button is held. Runs on the 100 MHz system clock.

Parameters:
- DEBOUNCE_CYCLES, 1_000_000, consecutive stable samples needed to accept a press or a release (10 ms at 100 MHz); legal range 2..2^24-1.
- REPEAT_DELAY, 50_000_000, cycles from the first strobe of a hold to the first repeat strobe; 0 disables auto-repeat.
- REPEAT_PERIOD, 20_000_000, cycles between successive repeat strobes; must be >= 1 when REPEAT_DELAY != 0.

Ports:
- clk  input  1  system clock, 100 MHz
- reset  input  1  asynchronous, active-low reset
- btn_up_raw  input  1  raw button, low = pressed, asynchronous
- btn_down_raw  input  1  raw button, low = pressed, asynchronous
- btn_left_raw  input  1  raw button, low = pressed, asynchronous
- btn_right_raw  input  1  raw button, low = pressed, asynchronous
- up  output  1  active-low one-cycle move strobe
- down  output  1  active-low one-cycle move strobe
- left  output  1  active-low one-cycle move strobe
- right  output  1  active-low one-cycle move strobe
- held  output  4  debounced pressed level {up,down,left,right}, active-high, for status/LEDs

Behaviour:
- Reset:
  - Clock is clk; reset is asynchronous, active-low.
  - While reset is low: up/down/left/right = 1, held = 4'b0000, all synchronizer flops = 1 (released), all counters = 0, every channel in IDLE.
- Channels: four identical, independent channels; no arbitration. Simultaneous strobes are permitted and frogger resolves priority.
- Synchronizer: each raw input passes through a 2-flop synchronizer; its output s feeds the FSM.
- Per-channel FSM, states:
  - IDLE: s=0 -> PRESS_WAIT, cnt=0.
  - PRESS_WAIT:
    - s=1 -> IDLE (bounce rejected).
    - Else cnt++; when cnt reaches DEBOUNCE_CYCLES-1 -> HELD, strobe low for exactly the next cycle, held bit=1, rcnt=0.
  - HELD:
    - s=1 -> RELEASE_WAIT, cnt=0.
    - Else if REPEAT_DELAY!=0, rcnt++; at rcnt==REPEAT_DELAY-1 -> REPEAT, one strobe, rcnt=0.
  - REPEAT:
    - s=1 -> RELEASE_WAIT, cnt=0.
    - Else rcnt++; at rcnt==REPEAT_PERIOD-1 -> one strobe, rcnt=0.
  - RELEASE_WAIT:
    - s=0 -> back to HELD if entered from HELD, or to REPEAT if entered from REPEAT; rcnt is preserved, cnt=0, no strobe (release bounce rejected).
    - Else cnt++; at DEBOUNCE_CYCLES-1 -> IDLE, held bit=0.
- Latency: a clean press whose raw input is first sampled low at edge E0 produces its strobe low in the cycle that starts at edge E0+2+DEBOUNCE_CYCLES. The strobe is a single cycle; there is never a strobe on release.
- Registers: strobes and held are registered outputs, so there are no combinational paths from inputs.
- Counter widths: cnt is $clog2(DEBOUNCE_CYCLES) bits. rcnt is $clog2(max(REPEAT_DELAY,REPEAT_PERIOD)) bits. Counters never wrap, because each resets on its terminal compare.
- Reset mid-press: FSM returns to IDLE. After reset deassertion, a button still held must pass the full PRESS_WAIT again before producing a strobe; there are no stale strobes.
- A glitch shorter than DEBOUNCE_CYCLES in any state causes no state change visible at the outputs.

Decomposition:
- Shared package: channel state enum (IDLE, PRESS_WAIT, HELD, REPEAT, RELEASE_WAIT), direction index constants (DIR_UP=3, DIR_DOWN=2, DIR_LEFT=1, DIR_RIGHT=0), default timing constants.
- Sub-module debounce_channel: synchronizer + FSM + counters for one button, instantiated four times by button_conditioner. The top adds only wiring and output packing.

Test Plan (DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=8):
- Reset: reset=0 with all buttons pressed -> up/down/left/right=1 and held=0 for the whole reset. After release, the first up strobe is 6 cycles after the first post-reset sampling edge.
- Clean press: btn_up_raw low at edge 10, held low 100 cycles -> up low only in the cycle starting at edge 16. Repeat strobes follow at edges 36, 44, 52, ...; held[3]=1 from edge 16.
- Bounce: btn_left_raw toggles low 2 / high 1 cycles for 30 cycles, then stays low -> no strobe during toggling; exactly one left strobe 6 cycles after the final stable low begins.
- Release bounce: hold right for 10 cycles after its strobe, then pulse high 2 cycles and low again -> no second strobe; held[0] stays 1.
- Simultaneous: up and right pressed on the same edge -> up and right both low in the same single cycle; down and left stay 1.
- Repeat disabled (REPEAT_DELAY=0): hold down for 200 cycles -> exactly one down strobe; after release, held[2] clears 6 cycles after the raw rising edge.
